// File: rtl/sync_fifo.sv
// Single-clock FIFO with exact registered occupancy counts, almost-full/almost-empty flags
// and an optional first-word-fall-through head register. Port set matches the dual-clock FIFO.
module sync_fifo #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = 4,
  parameter int AE_THRESH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic                  iwr,
  output logic [ADDR_WIDTH:0]   iempty_count,
  output logic                  ialmost_full,
  output logic                  ioverflow,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  odata_valid,
  input  logic                  ord,
  output logic [ADDR_WIDTH:0]   ofull_count,
  output logic                  oalmost_empty,
  output logic                  ounderflow
);

  localparam int CW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LIM  = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LIM  = CW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]         wptr;
  logic [CW-1:0]         rptr;
  logic                  wr_ok;
  logic                  deq_ok;
  logic                  ram_rd;

  // Write acceptance looks only at the registered count, so a same-cycle pop never frees a slot.
  assign wr_ok = iwr && (iempty_count != '0) && !reset;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr[ADDR_WIDTH-1:0]] <= idata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + CW'(1);
      end
      if (ram_rd) begin
        rptr <= rptr + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ofull_count  <= '0;
      iempty_count <= DEPTH_C;
      ioverflow    <= 1'b0;
      ounderflow   <= 1'b0;
    end else begin
      ioverflow  <= iwr && !wr_ok;
      ounderflow <= ord && !deq_ok;
      case ({wr_ok, deq_ok})
        2'b10: begin
          ofull_count  <= ofull_count + CW'(1);
          iempty_count <= iempty_count - CW'(1);
        end
        2'b01: begin
          ofull_count  <= ofull_count - CW'(1);
          iempty_count <= iempty_count + CW'(1);
        end
        default: begin
          ofull_count  <= ofull_count;
          iempty_count <= iempty_count;
        end
      endcase
    end
  end

  assign ialmost_full  = (iempty_count <= AF_LIM);
  assign oalmost_empty = (ofull_count <= AE_LIM);

  generate
    if (FWFT != 0) begin : g_fwft
      logic                  head_valid;
      logic [DATA_WIDTH-1:0] head_data;
      logic                  ram_empty;

      // The head word counts as stored; the RAM is refilled from whenever the head is free or popped.
      assign ram_empty = (wptr == rptr);
      assign deq_ok    = ord && head_valid && !reset;
      assign ram_rd    = !reset && !ram_empty && (!head_valid || deq_ok);

      always_ff @(posedge clk) begin
        if (reset) begin
          head_valid <= 1'b0;
          head_data  <= '0;
        end else if (ram_rd) begin
          head_valid <= 1'b1;
          head_data  <= mem[rptr[ADDR_WIDTH-1:0]];
        end else if (deq_ok) begin
          head_valid <= 1'b0;
        end
      end

      assign odata       = head_data;
      assign odata_valid = head_valid;
    end else begin : g_std
      assign deq_ok = ord && (ofull_count != '0) && !reset;
      assign ram_rd = deq_ok;

      always_ff @(posedge clk) begin
        if (reset) begin
          odata       <= '0;
          odata_valid <= 1'b0;
        end else begin
          odata_valid <= deq_ok;
          if (deq_ok) begin
            odata <= mem[rptr[ADDR_WIDTH-1:0]];
          end
        end
      end
    end
  endgenerate

endmodule
